// File: rtl/smpl_dump_ctrl.sv
// ============================================================================
// Module      : smpl_dump_ctrl
// Description : Streams one channel's circular capture buffer to the UART TX,
//               oldest sample first, one byte per RAM read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module smpl_dump_ctrl #(
    parameter int ENTRIES = 384,
    parameter int ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_start,
    input  logic [2:0]        dump_chan,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              abort,
    input  logic [7:0]        rdata1,
    input  logic [7:0]        rdata2,
    input  logic [7:0]        rdata3,
    input  logic [7:0]        rdata4,
    input  logic [7:0]        rdata5,
    input  logic              tx_done,
    output logic              ram_ren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        tx_data,
    output logic              trmt,
    output logic              dump_busy,
    output logic              dump_done,
    output logic              dump_nack
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(ENTRIES - 1);
    localparam logic [ADDR_W:0]   ENTRIES_W = (ADDR_W + 1)'(ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_XMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        chan;
    logic [ADDR_W-1:0] cnt;
    logic              trmt_q;
    logic [7:0]        rdata_sel;
    logic              chan_ok;
    logic              abort_act;
    logic              last_byte;

    assign chan_ok   = (dump_chan != 3'd0) && (dump_chan <= 3'd5);
    assign abort_act = abort && (state != S_IDLE);
    assign last_byte = (cnt == LAST_IDX);

    always_comb begin
        rdata_sel = 8'h00;
        case (chan)
            3'd1:    rdata_sel = rdata1;
            3'd2:    rdata_sel = rdata2;
            3'd3:    rdata_sel = rdata3;
            3'd4:    rdata_sel = rdata4;
            3'd5:    rdata_sel = rdata5;
            default: rdata_sel = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort overrides every transition, including a simultaneous tx_done.
    always_comb begin
        state_nxt = state;
        ram_ren   = 1'b0;
        dump_done = 1'b0;
        if (abort_act) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dump_start && chan_ok) begin
                        state_nxt = S_READ;
                    end
                end
                S_READ: begin
                    ram_ren   = 1'b1;
                    state_nxt = S_LATCH;
                end
                S_LATCH: begin
                    state_nxt = S_XMIT;
                end
                S_XMIT: begin
                    if (tx_done) begin
                        state_nxt = last_byte ? S_DONE : S_READ;
                    end
                end
                S_DONE: begin
                    dump_done = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign trmt = trmt_q && !abort_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan      <= 3'd0;
            cnt       <= '0;
            ram_addr  <= '0;
            tx_data   <= 8'h00;
            trmt_q    <= 1'b0;
            dump_busy <= 1'b0;
            dump_nack <= 1'b0;
        end else begin
            trmt_q    <= 1'b0;
            dump_nack <= 1'b0;
            if (abort_act) begin
                dump_busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (dump_start) begin
                            if (chan_ok) begin
                                chan      <= dump_chan;
                                cnt       <= '0;
                                dump_busy <= 1'b1;
                                // Out-of-range write pointer restarts at the buffer base.
                                ram_addr  <= ({1'b0, start_addr} >= ENTRIES_W) ? '0 : start_addr;
                            end else begin
                                dump_nack <= 1'b1;
                            end
                        end
                    end
                    S_LATCH: begin
                        tx_data <= rdata_sel;
                        trmt_q  <= 1'b1;
                    end
                    S_XMIT: begin
                        if (tx_done && !last_byte) begin
                            cnt      <= cnt + 1'b1;
                            ram_addr <= (ram_addr == LAST_IDX) ? '0 : ram_addr + 1'b1;
                        end
                    end
                    S_DONE: begin
                        dump_busy <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_smpl_dump_ctrl.sv
// ============================================================================
// Module      : tb_smpl_dump_ctrl
// Description : Self-checking bench for smpl_dump_ctrl with a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_smpl_dump_ctrl;

    localparam int ENTRIES = 8;
    localparam int ADDR_W  = 4;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              dump_start = 1'b0;
    logic [2:0]        dump_chan  = 3'd0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              abort      = 1'b0;
    logic              tx_done    = 1'b0;
    logic [7:0]        rdata1 = 8'h00, rdata2 = 8'h00, rdata3 = 8'h00, rdata4 = 8'h00, rdata5 = 8'h00;
    logic              ram_ren;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        tx_data;
    logic              trmt;
    logic              dump_busy;
    logic              dump_done;
    logic              dump_nack;

    smpl_dump_ctrl #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .dump_start(dump_start), .dump_chan(dump_chan),
        .start_addr(start_addr), .abort(abort),
        .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3), .rdata4(rdata4), .rdata5(rdata5),
        .tx_done(tx_done), .ram_ren(ram_ren), .ram_addr(ram_addr), .tx_data(tx_data),
        .trmt(trmt), .dump_busy(dump_busy), .dump_done(dump_done), .dump_nack(dump_nack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Sample content of channel k at address a; channel 3 is addr ^ A5.
    function automatic logic [7:0] byte_of(input int k, input int a);
        return 8'(a) ^ 8'hA5 ^ 8'(k << 4) ^ 8'h30;
    endfunction

    always @(posedge clk) begin
        if (ram_ren) begin
            rdata1 <= byte_of(1, int'(ram_addr));
            rdata2 <= byte_of(2, int'(ram_addr));
            rdata3 <= byte_of(3, int'(ram_addr));
            rdata4 <= byte_of(4, int'(ram_addr));
            rdata5 <= byte_of(5, int'(ram_addr));
        end
    end

    // Transaction model: which dump is live, which bytes/addresses remain.
    bit         m_busy = 0, e_done = 0, e_nack = 0, outstanding = 0;
    int         m_acked = 0;
    int         exp_addrs[$];
    logic [7:0] exp_bytes[$];

    always @(posedge clk) begin
        e_nack = 0;
        if (!rst_n) begin
            m_busy = 0; e_done = 0; outstanding = 0; m_acked = 0;
            exp_addrs.delete(); exp_bytes.delete();
        end else if (e_done) begin
            e_done = 0;
            m_busy = 0;
        end else if (m_busy && abort) begin
            m_busy = 0; outstanding = 0;
            exp_addrs.delete(); exp_bytes.delete();
        end else if (m_busy && tx_done && outstanding) begin
            outstanding = 0;
            m_acked++;
            if (m_acked == ENTRIES) e_done = 1;
        end else if (!m_busy && dump_start) begin
            if (dump_chan >= 3'd1 && dump_chan <= 3'd5) begin
                int sa;
                sa = (int'(start_addr) >= ENTRIES) ? 0 : int'(start_addr);
                m_busy  = 1;
                m_acked = 0;
                for (int i = 0; i < ENTRIES; i++) begin
                    exp_addrs.push_back((sa + i) % ENTRIES);
                    exp_bytes.push_back(byte_of(int'(dump_chan), (sa + i) % ENTRIES));
                end
            end else begin
                e_nack = 1;
            end
        end
    end

    int         ren_cycles[$];
    int         trmt_cycles[$];
    int         txd_edges[$];
    logic [7:0] sent[$];
    int         done_count = 0;
    int         nack_count = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("dump_busy", 32'(dump_busy), 32'(m_busy));
            check("dump_done", 32'(dump_done), 32'(e_done));
            check("dump_nack", 32'(dump_nack), 32'(e_nack));
            if (dump_done) done_count++;
            if (dump_nack) nack_count++;
            if (abort && m_busy) begin
                check("abort_ren", 32'(ram_ren), 32'd0);
                check("abort_trmt", 32'(trmt), 32'd0);
            end
            if (ram_ren) begin
                ren_cycles.push_back(cyc);
                check("ram_addr_range", 32'(ram_addr < ADDR_W'(ENTRIES)), 32'd1);
                if (exp_addrs.size() == 0) check("unexpected_ren", 32'(ram_ren), 32'd0);
                else check("ram_addr", 32'(ram_addr), 32'(exp_addrs.pop_front()));
            end
            if (trmt) begin
                trmt_cycles.push_back(cyc);
                sent.push_back(tx_data);
                outstanding = 1;
                if (exp_bytes.size() == 0) check("unexpected_trmt", 32'(trmt), 32'd0);
                else check("tx_data", 32'(tx_data), 32'(exp_bytes.pop_front()));
            end
        end
    end

    // UART stand-in: answers each trmt with tx_done after tx_delay cycles.
    int tx_delay  = 10;
    int tx_budget = 1000;
    initial begin
        forever begin
            @(negedge clk);
            if (trmt && tx_budget > 0) begin
                tx_budget--;
                repeat (tx_delay) @(posedge clk);
                #1 tx_done = 1'b1;
                txd_edges.push_back(cyc);
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    int s_edge = 0;

    task automatic start_dump(input logic [2:0] ch, input logic [ADDR_W-1:0] sa);
        @(posedge clk);
        #1 dump_start = 1'b1; dump_chan = ch; start_addr = sa; s_edge = cyc;
        @(posedge clk);
        #1 dump_start = 1'b0;
    endtask

    task automatic clear_logs();
        ren_cycles.delete(); trmt_cycles.delete(); txd_edges.delete(); sent.delete();
    endtask

    task automatic wait_done(input string nm, input int budget);
        int target;
        target = done_count + 1;
        for (int i = 0; i < budget && done_count < target; i++) @(negedge clk);
        check(nm, 32'(done_count), 32'(target));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_ram_ren"}, 32'(ram_ren), 32'd0);
        check({nm, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({nm, "_tx_data"}, 32'(tx_data), 32'd0);
        check({nm, "_trmt"}, 32'(trmt), 32'd0);
        check({nm, "_busy"}, 32'(dump_busy), 32'd0);
        check({nm, "_done"}, 32'(dump_done), 32'd0);
        check({nm, "_nack"}, 32'(dump_nack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit [8];
        int         d0;
        lit = '{8'hA0, 8'hA3, 8'hA2, 8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1};

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset");

        // Channel 3 from write pointer 5, wrapping through the end of the buffer.
        clear_logs();
        start_dump(3'd3, 4'd5);
        wait_done("dump1_done", 400);
        check("dump1_bytes", 32'(sent.size()), 32'd8);
        for (int i = 0; i < 8 && i < sent.size(); i++) check("dump1_lit", 32'(sent[i]), 32'(lit[i]));
        if (ren_cycles.size() > 1 && trmt_cycles.size() > 1 && txd_edges.size() > 0) begin
            check("lat_start_ren", 32'(ren_cycles[0] - s_edge), 32'd1);
            check("lat_start_trmt", 32'(trmt_cycles[0] - s_edge), 32'd3);
            check("lat_txd_ren", 32'(ren_cycles[1] - txd_edges[0]), 32'd1);
            check("lat_txd_trmt", 32'(trmt_cycles[1] - txd_edges[0]), 32'd3);
        end else begin
            check("lat_samples", 32'(trmt_cycles.size()), 32'd8);
        end
        check("dump1_ren_count", 32'(ren_cycles.size()), 32'd8);
        check("dump1_busy_after", 32'(dump_busy), 32'd0);

        // Invalid channels are refused without touching the RAMs.
        clear_logs();
        d0 = nack_count;
        start_dump(3'd0, 4'd0);
        repeat (3) @(negedge clk);
        start_dump(3'd6, 4'd2);
        repeat (3) @(negedge clk);
        check("nack_count", 32'(nack_count - d0), 32'd2);
        check("nack_no_ren", 32'(ren_cycles.size()), 32'd0);
        check("nack_no_trmt", 32'(trmt_cycles.size()), 32'd0);

        // A second request while busy must not disturb the running dump.
        clear_logs();
        tx_delay = 4;
        start_dump(3'd1, 4'd2);
        repeat (5) @(posedge clk);
        start_dump(3'd2, 4'd0);
        wait_done("dump2_done", 400);
        check("dump2_bytes", 32'(sent.size()), 32'd8);
        if (sent.size() == 8) begin
            check("dump2_first", 32'(sent[0]), 32'h87);
            check("dump2_last", 32'(sent[7]), 32'h84);
        end

        // Abort in XMIT on the 4th byte, colliding with its tx_done.
        clear_logs();
        tx_delay = 3; tx_budget = 3;
        d0 = done_count;
        start_dump(3'd1, 4'd4);
        for (int i = 0; i < 200 && trmt_cycles.size() < 4; i++) @(negedge clk);
        check("abort_reach_4th", 32'(trmt_cycles.size()), 32'd4);
        @(posedge clk);
        #1 abort = 1'b1; tx_done = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0; tx_done = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_trmt_total", 32'(trmt_cycles.size()), 32'd4);
        check("abort_no_done", 32'(done_count - d0), 32'd0);
        check("abort_idle", 32'(dump_busy), 32'd0);

        clear_logs();
        tx_budget = 1000;
        start_dump(3'd4, 4'd6);
        wait_done("dump3_done", 400);
        check("dump3_bytes", 32'(sent.size()), 32'd8);
        if (sent.size() > 0) check("dump3_first", 32'(sent[0]), 32'hD3);

        // Asynchronous reset in the middle of a RAM read.
        clear_logs();
        d0 = done_count;
        start_dump(3'd2, 4'd3);
        for (int i = 0; i < 20 && !ram_ren; i++) @(negedge clk);
        check("rst_saw_ren", 32'(ram_ren), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_done", 32'(done_count - d0), 32'd0);

        clear_logs();
        start_dump(3'd5, 4'd9);
        wait_done("dump4_done", 400);
        check("dump4_bytes", 32'(sent.size()), 32'd8);
        if (sent.size() > 0) check("dump4_wrap_base", 32'(sent[0]), 32'hC5);
        check("model_drained", 32'(exp_bytes.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/smpl_dump_ctrl.md
Name: smpl_dump_ctrl

Overview:
Reads captured samples back out of the five per-channel capture RAMs written during acquisition and streams them byte-by-byte to the UART transmitter. On a dump command it walks the circular capture buffer of one selected channel, from the oldest sample at the write pointer through ENTRIES bytes with address wrap. It sits between the command processor, the capture RAMs' read ports and the UART TX.

Parameters:
ENTRIES, 384, number of samples held per channel RAM; addresses 0..ENTRIES-1
ADDR_W, 9, address width; must satisfy 2^ADDR_W >= ENTRIES

Ports:
clk  input  1  system clock (capture-domain clk, not smpl_clk)
rst_n  input  1  asynchronous active-low reset
dump_start  input  1  one-cycle dump request from the command processor
dump_chan  input  3  channel to dump; valid values 1..5
start_addr  input  ADDR_W  oldest-sample address, which is the capture write pointer
abort  input  1  synchronous cancel of an in-progress dump
rdata1..rdata5  input  8 each  RAM read data, valid one cycle after ram_ren
tx_done  input  1  UART TX one-cycle pulse: byte fully shifted out
ram_ren  output  1  RAM read enable, common to all five RAMs
ram_addr  output  ADDR_W  RAM read address
tx_data  output  8  byte presented to the UART
trmt  output  1  one-cycle pulse: start transmitting tx_data
dump_busy  output  1  high from acceptance until DONE/abort
dump_done  output  1  one-cycle pulse when the last byte's tx_done is seen
dump_nack  output  1  one-cycle pulse: request rejected for an invalid channel

Behaviour:
- Reset values (async, rst_n low): state IDLE. ram_ren=0, ram_addr=0, tx_data=0, trmt=0, dump_busy=0, dump_done=0, dump_nack=0. Byte counter and channel register are 0.
- States: IDLE, READ, LATCH, XMIT, DONE.
- IDLE:
  - dump_start with dump_chan in 1..5: latch the channel, set ram_addr<=start_addr, clear the counter, set dump_busy<=1, go to READ.
  - dump_start with dump_chan in {0,6,7}: pulse dump_nack next cycle and stay in IDLE.
  - start_addr >= ENTRIES: treated as 0.
- READ (1 cycle): ram_ren=1 (state-decoded) with ram_addr stable, then go to LATCH.
- LATCH (1 cycle): tx_data <= rdata of the latched channel, trmt <= 1 (registered), then go to XMIT.
- XMIT:
  - trmt is high only in the first XMIT cycle.
  - Wait for tx_done. On tx_done with count==ENTRIES-1, go to DONE.
  - Otherwise count++, ram_addr <= (ram_addr==ENTRIES-1) ? 0 : ram_addr+1, go to READ.
- DONE (1 cycle): dump_done=1, dump_busy<=0, return to IDLE.
- Latency:
  - dump_start sampled at edge 0 gives ram_ren high in cycle 1 and trmt high in cycle 3.
  - tx_done at edge N gives the next ram_ren in cycle N+1 and the next trmt in cycle N+3.
- Exactly ENTRIES bytes are sent per dump, in address order start_addr, start_addr+1 ... with wrap. ram_addr never reaches ENTRIES.
- dump_start while busy: ignored, no nack.
- tx_done outside XMIT: ignored.
- tx_done in the same cycle trmt is high: accepted; the bench must not depend on this.
- abort (any non-IDLE state): next state IDLE, dump_busy<=0, trmt and ram_ren forced 0, no dump_done. abort wins over a simultaneous tx_done. abort in IDLE has no effect.
- abort and dump_start in the same IDLE cycle: dump_start is accepted.
- rst_n low mid-dump: immediate return to reset values. No dump_done.
- The channel register does not change during a dump, even if dump_chan changes.

Test Plan:
- ENTRIES=8, chan=3, start_addr=5, rdata3=addr^8'hA5, tx_done 10 cycles after each trmt -> 8 trmt pulses, bytes for addresses 5,6,7,0,1,2,3,4 (A0,A3,A2,A5,A4,A7,A6,A1); dump_done once after the 8th tx_done; busy low after that.
- Latency check: dump_start at cycle 0 -> ram_ren only in cycle 1, trmt only in cycle 3. tx_done at cycle 20 -> ram_ren in cycle 21, trmt in cycle 23.
- dump_chan=0 and then 6 -> one dump_nack per request, busy stays 0, no ram_ren or trmt.
- dump_start with chan=2 during an active chan=1 dump -> ignored; all bytes come from rdata1; count unchanged.
- abort while in XMIT after the 3rd byte, with tx_done asserted the same cycle -> IDLE next cycle, no further trmt, no dump_done. A following dump starts cleanly at its own start_addr.
- rst_n pulsed low mid-READ -> all outputs 0 asynchronously. After release, a new dump of ENTRIES=8 completes normally.
